// File: rtl/tone_note_decoder_pkg.sv
// tone_note_decoder_pkg
//   Shared constants for the tone note decoder: note codes, nominal tone
//   periods (clk cycles at 100 MHz), default widths/tolerances, and the
//   period classifier.
package tone_note_decoder_pkg;

  typedef enum logic [3:0] {
    NOTE_NONE = 4'd0,
    NOTE_F3   = 4'd1,
    NOTE_G3   = 4'd2,
    NOTE_A3   = 4'd3,
    NOTE_B3   = 4'd4,
    NOTE_C4   = 4'd5,
    NOTE_D4   = 4'd6,
    NOTE_E4   = 4'd7,
    NOTE_G4   = 4'd8
  } note_e;

  localparam int unsigned CNT_W_DEF   = 20;
  localparam int unsigned TOL_DEF     = 8000;
  localparam int unsigned MATCH_DEF   = 3;
  localparam int unsigned TIMEOUT_DEF = 1048575;

  // Entry k holds the nominal period of note code k+1.
  typedef logic [7:0][31:0] ptab_t;

  localparam ptab_t P_NOM = {
    32'd255102,  // G4
    32'd303370,  // E4
    32'd340518,  // D4
    32'd382220,  // C4
    32'd404956,  // B3
    32'd454546,  // A3
    32'd510204,  // G3
    32'd572704   // F3
  };

  // Bands are disjoint for sane tolerances, so at most one entry matches.
  function automatic logic [3:0] classify(input logic [31:0] cnt,
                                          input ptab_t       tab,
                                          input logic [31:0] tol);
    logic [3:0]  code;
    logic [31:0] diff;
    code = 4'd0;
    for (int k = 0; k < 8; k++) begin
      diff = (cnt >= tab[k]) ? (cnt - tab[k]) : (tab[k] - cnt);
      if (diff <= tol) code = 4'(k + 1);
    end
    return code;
  endfunction

endpackage

// File: rtl/tone_note_decoder_if.sv
// tone_note_decoder_if
//   Result bus of the tone note decoder.
//   note        decoded note code (0 = none)
//   note_valid  a note is locked
//   note_strobe one-cycle pulse on every note change
//   period      last completed period measurement, clk cycles
interface tone_note_decoder_if #(parameter int unsigned CNT_W = 20);
  logic [3:0]       note;
  logic             note_valid;
  logic             note_strobe;
  logic [CNT_W-1:0] period;

  modport master (output note, note_valid, note_strobe, period);
  modport slave  (input  note, note_valid, note_strobe, period);
endinterface

// File: rtl/tone_note_decoder_sync_edge.sv
// tone_note_decoder_sync_edge
//   Two-flop synchronizer for the asynchronous tone pin followed by a
//   rising-edge detector.
//   clk    system clock
//   reset  synchronous, active-high
//   din    asynchronous tone input
//   rise   one-cycle pulse per synchronized rising edge
module tone_note_decoder_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic rise
);
  logic meta, s1, s2;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= 1'b0;
      s1   <= 1'b0;
      s2   <= 1'b0;
    end else begin
      meta <= din;
      s1   <= meta;
      s2   <= s1;
    end
  end

  assign rise = s1 & ~s2;
endmodule

// File: rtl/tone_note_decoder.sv
// tone_note_decoder
//   Measures the period of a square-wave tone and decodes it to a note code
//   once MATCH_COUNT consecutive periods agree. Silence longer than TIMEOUT
//   clears the note.
//   clk      system clock (100 MHz)
//   reset    synchronous, active-high
//   tone_in  asynchronous tone input
//   out_if   note / note_valid / note_strobe / period
//
//   state  | meaning
//   IDLE   | no edge seen yet (or silence); counter not trusted
//   ACQ    | edges arriving, no note locked
//   LOCK   | note locked; changes only after MATCH_COUNT new matches
module tone_note_decoder
  import tone_note_decoder_pkg::*;
#(
  parameter int unsigned CNT_W       = CNT_W_DEF,
  parameter int unsigned TOL         = TOL_DEF,
  parameter int unsigned MATCH_COUNT = MATCH_DEF,
  parameter int unsigned TIMEOUT     = TIMEOUT_DEF,
  parameter ptab_t       P_TAB       = P_NOM
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        tone_in,
  tone_note_decoder_if.master         out_if
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ACQ  = 2'd1;
  localparam logic [1:0] S_LOCK = 2'd2;

  localparam logic [2:0] MC = 3'(MATCH_COUNT);

  logic             rise;
  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [3:0]       note_q, note_d;
  logic [3:0]       cand_q, cand_d;
  logic [2:0]       run_q, run_d;
  logic             strobe_q;
  logic [3:0]       code;

  tone_note_decoder_sync_edge u_sync (
    .clk   (clk),
    .reset (reset),
    .din   (tone_in),
    .rise  (rise)
  );

  assign code = classify(32'(cnt_q), P_TAB, 32'(TOL));

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    period_d = period_q;
    note_d   = note_q;
    cand_d   = cand_q;
    run_d    = run_q;

    if (rise) begin
      cnt_d = CNT_W'(1);
      if (state_q == S_IDLE) begin
        state_d = S_ACQ;
      end else begin
        period_d = cnt_q;
        if (code == 4'd0) begin
          cand_d = 4'd0;
          run_d  = 3'd0;
        end else if (code == cand_q) begin
          run_d = (run_q >= MC) ? MC : run_q + 3'd1;
        end else begin
          cand_d = code;
          run_d  = 3'd1;
        end
        if (code != 4'd0 && run_d == MC && cand_d != note_q) begin
          note_d  = cand_d;
          state_d = S_LOCK;
        end
      end
    end else begin
      if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_W'(1);
      // An edge in the same cycle as the timeout takes the branch above.
      if (state_q != S_IDLE && cnt_q >= CNT_W'(TIMEOUT)) begin
        state_d = S_IDLE;
        note_d  = 4'd0;
        cand_d  = 4'd0;
        run_d   = 3'd0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      period_q <= '0;
      note_q   <= 4'd0;
      cand_q   <= 4'd0;
      run_q    <= 3'd0;
      strobe_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      period_q <= period_d;
      note_q   <= note_d;
      cand_q   <= cand_d;
      run_q    <= run_d;
      strobe_q <= (note_d != note_q);
    end
  end

  assign out_if.note        = note_q;
  assign out_if.note_valid  = (state_q == S_LOCK) && (note_q != 4'd0);
  assign out_if.note_strobe = strobe_q;
  assign out_if.period      = period_q;

endmodule

// File: tb/tb_tone_note_decoder.sv
// tb_tone_note_decoder
//   Directed bench for tone_note_decoder with a note-change scoreboard.
//   Periods are scaled down (A3 = 455 cycles etc.) so runs stay short.
module tb_tone_note_decoder;
  import tone_note_decoder_pkg::*;

  localparam int unsigned CW = 12;
  localparam ptab_t TB_TAB = {
    32'd255, 32'd303, 32'd341, 32'd382, 32'd405, 32'd455, 32'd510, 32'd573
  };

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic tone = 1'b0;
  int   checks = 0;
  int   failures = 0;
  logic [3:0] exp_q[$];

  always #5 clk = ~clk;

  tone_note_decoder_if #(.CNT_W(CW)) bus ();

  tone_note_decoder #(
    .CNT_W(CW), .TOL(8), .MATCH_COUNT(3), .TIMEOUT(1000), .P_TAB(TB_TAB)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .tone_in (tone),
    .out_if  (bus)
  );

  // Scoreboard monitor: every strobe must match the next expected note.
  always @(negedge clk) begin
    if (bus.note_strobe) begin
      logic [3:0] e;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL strobe_unexpected note=%0d required=no strobe", bus.note);
      end else begin
        e = exp_q.pop_front();
        if (bus.note !== e || bus.note_valid !== (e != 4'd0)) begin
          failures++;
          $display("FAIL strobe_note note=%0d valid=%0b required note=%0d valid=%0b",
                   bus.note, bus.note_valid, e, (e != 4'd0));
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // n rising edges spaced p cycles apart; line ends low.
  task automatic send(input int p, input int n);
    for (int i = 0; i < n; i++) begin
      tone = 1'b1;
      repeat ((p + 1) / 2) @(negedge clk);
      tone = 1'b0;
      repeat (p / 2) @(negedge clk);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    repeat (4) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_note",   32'(bus.note), 0);
    chk("rst_valid",  32'(bus.note_valid), 0);
    chk("rst_strobe", 32'(bus.note_strobe), 0);
    chk("rst_period", 32'(bus.period), 0);

    // A3 lock from reset: first edge + three periods.
    exp_q.push_back(4'(NOTE_A3));
    send(455, 4);
    chk("a3_note",   32'(bus.note), 32'(NOTE_A3));
    chk("a3_valid",  32'(bus.note_valid), 1);
    chk("a3_period", 32'(bus.period), 455);

    // Switch to E4: first E4 edge still measures an A3 period.
    send(303, 3);
    chk("e4_hold_note", 32'(bus.note), 32'(NOTE_A3));
    exp_q.push_back(4'(NOTE_E4));
    send(303, 1);
    chk("e4_note", 32'(bus.note), 32'(NOTE_E4));

    // Relock A3, then one unmatched 420-cycle period.
    exp_q.push_back(4'(NOTE_A3));
    send(455, 4);
    send(420, 2);
    chk("unm_period", 32'(bus.period), 420);
    chk("unm_note",   32'(bus.note), 32'(NOTE_A3));
    chk("unm_valid",  32'(bus.note_valid), 1);

    // Silence: note clears TIMEOUT (+ sync latency) cycles after last edge.
    exp_q.push_back(4'd0);
    n = 0;
    while (bus.note != 4'd0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("to_note",  32'(bus.note), 0);
    chk("to_valid", 32'(bus.note_valid), 0);
    chk("to_latency_ok", 32'((420 + n) >= 1000 && (420 + n) <= 1010), 1);

    // Reset two periods into a C4 acquisition.
    send(382, 3);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_note",   32'(bus.note), 0);
    chk("mid_rst_valid",  32'(bus.note_valid), 0);
    chk("mid_rst_strobe", 32'(bus.note_strobe), 0);
    chk("mid_rst_period", 32'(bus.period), 0);
    reset = 1'b0;
    @(negedge clk);
    send(382, 3);
    chk("relock_partial_note", 32'(bus.note), 0);
    exp_q.push_back(4'(NOTE_C4));
    send(382, 1);
    chk("relock_note", 32'(bus.note), 32'(NOTE_C4));

    // C4 band edges, probed from an E4 lock.
    exp_q.push_back(4'(NOTE_E4));
    send(303, 4);
    send(391, 4);
    chk("hi_out_period", 32'(bus.period), 391);
    chk("hi_out_note",   32'(bus.note), 32'(NOTE_E4));
    exp_q.push_back(4'(NOTE_C4));
    send(390, 4);
    chk("hi_in_period", 32'(bus.period), 390);
    chk("hi_in_note",   32'(bus.note), 32'(NOTE_C4));
    exp_q.push_back(4'(NOTE_E4));
    send(303, 4);
    send(373, 4);
    chk("lo_out_period", 32'(bus.period), 373);
    chk("lo_out_note",   32'(bus.note), 32'(NOTE_E4));
    exp_q.push_back(4'(NOTE_C4));
    send(374, 4);
    chk("lo_in_period", 32'(bus.period), 374);
    chk("lo_in_note",   32'(bus.note), 32'(NOTE_C4));

    repeat (5) @(negedge clk);
    chk("pending_strobes", 32'(exp_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
